// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : Single-outstanding load/store engine between a core and a DDR3
//             IP command/data port. Handles lane placement, byte masks, load
//             sign/zero extension, misalignment rejection and wait timeouts.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_unit #(
    parameter int DDR_W   = 32,
    parameter int ADDR_W  = 29,
    parameter int DST_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [2:0]           op_i,
    input  logic [ADDR_W-1:0]    memory_address_i,
    input  logic [31:0]          store_data_i,
    input  logic [DST_W-1:0]     destination_i,
    output logic                 wb_valid_o,
    output logic [31:0]          wb_data_o,
    output logic [DST_W-1:0]     destination_o,
    output logic                 done_o,
    output logic                 misalign_o,
    output logic                 timeout_o,
    input  logic                 ddr_cmd_rdy_i,
    output logic                 ddr_enable_o,
    output logic                 ddr_cmd_o,
    output logic [ADDR_W-1:0]    ddr_addr_o,
    output logic [DDR_W-1:0]     ddr_wr_data_o,
    output logic [DDR_W/8-1:0]   ddr_wr_mask_o,
    input  logic [DDR_W-1:0]     ddr_read_data_i,
    input  logic                 ddr_read_data_valid_i,
    input  logic                 ddr_read_data_end_i
);

    localparam int          c_BYTES     = DDR_W / 8;
    localparam int          c_OFF_W     = $clog2(c_BYTES);
    localparam logic [15:0] c_WAIT_LAST = 16'(TIMEOUT - 1);

    localparam logic [2:0] c_OP_LB  = 3'b000;
    localparam logic [2:0] c_OP_LBU = 3'b001;
    localparam logic [2:0] c_OP_LH  = 3'b010;
    localparam logic [2:0] c_OP_LHU = 3'b011;
    localparam logic [2:0] c_OP_SB  = 3'b101;
    localparam logic [2:0] c_OP_SH  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CMD    = 2'd1,
        S_RDWAIT = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    // latched request context
    logic [2:0]          r_op;
    logic [c_OFF_W-1:0]  r_off;
    logic                r_is_store;
    logic [DST_W-1:0]    r_dst;
    logic [15:0]         r_wait_cnt;

    // registered DDR command fields
    logic                r_ddr_cmd;
    logic [ADDR_W-1:0]   r_ddr_addr;
    logic [DDR_W-1:0]    r_ddr_wdata;
    logic [c_BYTES-1:0]  r_ddr_mask;

    // request decode
    logic                w_req_byte;
    logic                w_req_half;
    logic                w_req_word;
    logic                w_req_store;
    logic                w_req_misaligned;
    logic [c_OFF_W-1:0]  w_req_off;
    logic [c_BYTES-1:0]  w_req_lanes;
    logic [DDR_W-1:0]    w_req_wdata;

    // load path
    logic [DDR_W-1:0]    w_rd_shifted;
    logic [31:0]         w_ld_value;

    // FSM events
    logic                w_accept;
    logic                w_misalign;
    logic                w_st_done;
    logic                w_ld_done;
    logic                w_timeout;
    logic                w_wait_expired;

    assign ready_o        = (r_state == S_IDLE);
    assign ddr_enable_o   = (r_state == S_CMD);
    assign ddr_cmd_o      = r_ddr_cmd;
    assign ddr_addr_o     = r_ddr_addr;
    assign ddr_wr_data_o  = r_ddr_wdata;
    assign ddr_wr_mask_o  = r_ddr_mask;
    assign w_wait_expired = (r_wait_cnt == c_WAIT_LAST);

    // Decode access size, alignment, active byte lanes and replicated store data
    always_comb begin
        w_req_byte       = (op_i == c_OP_LB) || (op_i == c_OP_LBU) || (op_i == c_OP_SB);
        w_req_half       = (op_i == c_OP_LH) || (op_i == c_OP_LHU) || (op_i == c_OP_SH);
        w_req_word       = !w_req_byte && !w_req_half;
        w_req_store      = op_i[2] && (op_i[1:0] != 2'b00);
        w_req_misaligned = (w_req_half && memory_address_i[0]) ||
                           (w_req_word && (memory_address_i[1:0] != 2'b00));
        w_req_off        = memory_address_i[c_OFF_W-1:0];
        if (w_req_byte) begin
            w_req_lanes = c_BYTES'(1);
            w_req_wdata = {c_BYTES{store_data_i[7:0]}};
        end else if (w_req_half) begin
            w_req_lanes = c_BYTES'(3);
            w_req_wdata = {(DDR_W/16){store_data_i[15:0]}};
        end else begin
            w_req_lanes = c_BYTES'(15);
            w_req_wdata = {(DDR_W/32){store_data_i}};
        end
        w_req_lanes = w_req_lanes << w_req_off;
    end

    // Select the addressed bytes of the read beat and extend to 32 bits
    always_comb begin
        w_rd_shifted = ddr_read_data_i >> {r_off, 3'b000};
        case (r_op)
            c_OP_LB:  w_ld_value = {{24{w_rd_shifted[7]}}, w_rd_shifted[7:0]};
            c_OP_LBU: w_ld_value = {24'd0, w_rd_shifted[7:0]};
            c_OP_LH:  w_ld_value = {{16{w_rd_shifted[15]}}, w_rd_shifted[15:0]};
            c_OP_LHU: w_ld_value = {16'd0, w_rd_shifted[15:0]};
            default:  w_ld_value = w_rd_shifted[31:0];
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and retirement events
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_misalign   = 1'b0;
        w_st_done    = 1'b0;
        w_ld_done    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (valid_i) begin
                    w_accept = 1'b1;
                    if (w_req_misaligned) begin
                        w_misalign = 1'b1;
                    end else begin
                        w_state_next = S_CMD;
                    end
                end
            end
            S_CMD: begin
                // acceptance wins over expiry in the same cycle
                if (ddr_cmd_rdy_i) begin
                    if (r_is_store) begin
                        w_st_done    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_RDWAIT;
                    end
                end else if (w_wait_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_RDWAIT: begin
                if (ddr_read_data_valid_i) begin
                    w_ld_done    = 1'b1;
                    w_state_next = ddr_read_data_end_i ? S_IDLE : S_DRAIN;
                end else if (w_wait_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (ddr_read_data_valid_i && ddr_read_data_end_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Wait counter: restarts on every state change, counts only while waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= 16'd0;
        end else if (w_state_next != r_state) begin
            r_wait_cnt <= 16'd0;
        end else if ((r_state == S_CMD) || (r_state == S_RDWAIT)) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    // Capture request context and the DDR command image on acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= 3'd0;
            r_off       <= '0;
            r_is_store  <= 1'b0;
            r_dst       <= '0;
            r_ddr_cmd   <= 1'b0;
            r_ddr_addr  <= '0;
            r_ddr_wdata <= '0;
            r_ddr_mask  <= '0;
        end else if (w_accept) begin
            r_op       <= op_i;
            r_off      <= w_req_off;
            r_is_store <= w_req_store;
            r_dst      <= destination_i;
            if (!w_req_misaligned) begin
                r_ddr_cmd   <= w_req_store;
                r_ddr_addr  <= memory_address_i & ~ADDR_W'(c_BYTES - 1);
                r_ddr_wdata <= w_req_wdata;
                // reads write nothing, so every byte stays masked
                r_ddr_mask  <= w_req_store ? ~w_req_lanes : '1;
            end
        end
    end

    // Retirement pulses and writeback result
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_o    <= 1'b0;
            done_o        <= 1'b0;
            misalign_o    <= 1'b0;
            timeout_o     <= 1'b0;
            wb_data_o     <= 32'd0;
            destination_o <= '0;
        end else begin
            wb_valid_o <= w_ld_done;
            misalign_o <= w_misalign;
            timeout_o  <= w_timeout;
            done_o     <= w_ld_done | w_st_done | w_misalign | w_timeout;
            if (w_ld_done) begin
                wb_data_o <= w_ld_value;
            end
            if (w_misalign) begin
                destination_o <= destination_i;
            end else if (w_ld_done || w_st_done || w_timeout) begin
                destination_o <= r_dst;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Self-checking bench for mem_access_unit: directed corner cases
//             followed by randomized transactions against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int DDR_W   = 32;
    localparam int ADDR_W  = 29;
    localparam int DST_W   = 32;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_i;
    logic              ready_o;
    logic [2:0]        op_i;
    logic [ADDR_W-1:0] memory_address_i;
    logic [31:0]       store_data_i;
    logic [DST_W-1:0]  destination_i;
    logic              wb_valid_o;
    logic [31:0]       wb_data_o;
    logic [DST_W-1:0]  destination_o;
    logic              done_o;
    logic              misalign_o;
    logic              timeout_o;
    logic              ddr_cmd_rdy_i;
    logic              ddr_enable_o;
    logic              ddr_cmd_o;
    logic [ADDR_W-1:0] ddr_addr_o;
    logic [DDR_W-1:0]  ddr_wr_data_o;
    logic [DDR_W/8-1:0] ddr_wr_mask_o;
    logic [DDR_W-1:0]  ddr_read_data_i;
    logic              ddr_read_data_valid_i;
    logic              ddr_read_data_end_i;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_wb = 32'd0;

    mem_access_unit #(
        .DDR_W   (DDR_W),
        .ADDR_W  (ADDR_W),
        .DST_W   (DST_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .valid_i               (valid_i),
        .ready_o               (ready_o),
        .op_i                  (op_i),
        .memory_address_i      (memory_address_i),
        .store_data_i          (store_data_i),
        .destination_i         (destination_i),
        .wb_valid_o            (wb_valid_o),
        .wb_data_o             (wb_data_o),
        .destination_o         (destination_o),
        .done_o                (done_o),
        .misalign_o            (misalign_o),
        .timeout_o             (timeout_o),
        .ddr_cmd_rdy_i         (ddr_cmd_rdy_i),
        .ddr_enable_o          (ddr_enable_o),
        .ddr_cmd_o             (ddr_cmd_o),
        .ddr_addr_o            (ddr_addr_o),
        .ddr_wr_data_o         (ddr_wr_data_o),
        .ddr_wr_mask_o         (ddr_wr_mask_o),
        .ddr_read_data_i       (ddr_read_data_i),
        .ddr_read_data_valid_i (ddr_read_data_valid_i),
        .ddr_read_data_end_i   (ddr_read_data_end_i)
    );

    always #5 clk = ~clk;

    // single comparison point: counts every check and reports mismatches
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one clock; outputs are read 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int op_size(input logic [2:0] op);
        case (op)
            3'd0, 3'd1, 3'd5: return 1;
            3'd2, 3'd3, 3'd6: return 2;
            default:          return 4;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] op, input int off, input logic [31:0] beat);
        logic [31:0] v;
        v = beat >> (8 * off);
        case (op_size(op))
            1: begin
                v = v % 32'd256;
                if (op == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            2: begin
                v = v % 32'd65536;
                if (op == 3'd2 && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] exp_wdata(input int sz, input logic [31:0] d);
        logic [31:0] w;
        w = 32'd0;
        for (int b = 0; b < 4; b++) begin
            w = w | (((d >> (8 * (b % sz))) & 32'hFF) << (8 * b));
        end
        return w;
    endfunction

    function automatic logic [3:0] exp_mask(input int off, input int sz);
        logic [3:0] m;
        m = 4'hF;
        for (int b = 0; b < 4; b++) begin
            if (b >= off && b < off + sz) m[b] = 1'b0;
        end
        return m;
    endfunction

    // One complete request from issue to retirement, DDR side driven by plan
    task automatic run_txn(input logic [2:0] op, input logic [ADDR_W-1:0] addr,
                           input logic [31:0] sdata, input logic [DST_W-1:0] tag,
                           input int cmd_dly, input int rd_dly, input logic [31:0] beat,
                           input int drain_beats, input bit noise);
        int          off;
        int          sz;
        bit          mis;
        bit          is_st;
        bit          got;
        logic [31:0] exp_v;
        off   = int'(addr[1:0]);
        sz    = op_size(op);
        mis   = (off % sz) != 0;
        is_st = (op >= 3'd5);
        got   = 1'b0;

        check_eq("ready_before_req", 64'(ready_o), 64'd1);
        check_eq("wb_data_hold", 64'(wb_data_o), 64'(last_wb));
        valid_i          = 1'b1;
        op_i             = op;
        memory_address_i = addr;
        store_data_i     = sdata;
        destination_i    = tag;
        tick();
        valid_i          = 1'b0;
        op_i             = 3'($urandom);
        memory_address_i = ADDR_W'($urandom);
        store_data_i     = $urandom;
        destination_i    = DST_W'($urandom);

        if (mis) begin
            check_eq("misalign_pulse", 64'({misalign_o, done_o, timeout_o, wb_valid_o}), 64'b1100);
            check_eq("misalign_no_cmd", 64'({ddr_enable_o, ready_o}), 64'b01);
            tick();
            check_eq("misalign_one_cycle", 64'({misalign_o, done_o, ddr_enable_o, ready_o}), 64'b0001);
            return;
        end

        for (int i = 0; i < TIMEOUT; i++) begin
            check_eq("cmd_enable", 64'({ddr_enable_o, ready_o}), 64'b10);
            check_eq("cmd_no_pulse", 64'({misalign_o, done_o, timeout_o, wb_valid_o}), 64'd0);
            check_eq("cmd_dir", 64'(ddr_cmd_o), 64'(is_st));
            check_eq("cmd_addr", 64'(ddr_addr_o), 64'(addr - ADDR_W'(off)));
            if (is_st) begin
                check_eq("cmd_wdata", 64'(ddr_wr_data_o), 64'(exp_wdata(sz, sdata)));
                check_eq("cmd_mask", 64'(ddr_wr_mask_o), 64'(exp_mask(off, sz)));
            end
            ddr_cmd_rdy_i = (i == cmd_dly);
            if (noise) begin
                ddr_read_data_valid_i = 1'($urandom);
                ddr_read_data_end_i   = 1'($urandom);
                ddr_read_data_i       = $urandom;
            end
            tick();
            ddr_cmd_rdy_i         = 1'b0;
            ddr_read_data_valid_i = 1'b0;
            ddr_read_data_end_i   = 1'b0;
            if (i == cmd_dly) begin
                got = 1'b1;
                break;
            end
        end

        if (!got) begin
            check_eq("cmd_timeout_pulse", 64'({misalign_o, done_o, timeout_o, wb_valid_o}), 64'b0110);
            check_eq("cmd_timeout_idle", 64'({ddr_enable_o, ready_o}), 64'b01);
            return;
        end
        if (is_st) begin
            check_eq("store_done", 64'({misalign_o, done_o, timeout_o, wb_valid_o}), 64'b0100);
            check_eq("store_idle", 64'({ddr_enable_o, ready_o}), 64'b01);
            return;
        end

        got = 1'b0;
        for (int j = 0; j < TIMEOUT; j++) begin
            check_eq("rdwait_busy", 64'({ddr_enable_o, ready_o}), 64'b00);
            check_eq("rdwait_no_pulse", 64'({misalign_o, done_o, timeout_o, wb_valid_o}), 64'd0);
            if (j == rd_dly) begin
                ddr_read_data_valid_i = 1'b1;
                ddr_read_data_end_i   = (drain_beats == 0);
                ddr_read_data_i       = beat;
            end else if (noise) begin
                ddr_read_data_i     = $urandom;
                ddr_read_data_end_i = 1'($urandom);
            end
            tick();
            ddr_read_data_valid_i = 1'b0;
            ddr_read_data_end_i   = 1'b0;
            if (j == rd_dly) begin
                got = 1'b1;
                break;
            end
        end

        if (!got) begin
            check_eq("rd_timeout_pulse", 64'({misalign_o, done_o, timeout_o, wb_valid_o}), 64'b0110);
            check_eq("rd_timeout_idle", 64'({ddr_enable_o, ready_o}), 64'b01);
            ddr_read_data_valid_i = 1'b1;
            ddr_read_data_end_i   = 1'b1;
            ddr_read_data_i       = beat;
            tick();
            ddr_read_data_valid_i = 1'b0;
            ddr_read_data_end_i   = 1'b0;
            check_eq("stray_beat_ignored", 64'({misalign_o, done_o, timeout_o, wb_valid_o, ready_o}), 64'b00001);
            return;
        end

        exp_v = exp_load(op, off, beat);
        check_eq("load_pulse", 64'({misalign_o, done_o, timeout_o, wb_valid_o}), 64'b0101);
        check_eq("load_data", 64'(wb_data_o), 64'(exp_v));
        check_eq("load_tag", 64'(destination_o), 64'(tag));
        last_wb = exp_v;
        check_eq("load_ready", 64'(ready_o), 64'(drain_beats == 0));

        for (int k = 0; k < drain_beats; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                tick();
                check_eq("drain_gap_busy", 64'({ready_o, wb_valid_o, done_o}), 64'b000);
            end
            ddr_read_data_valid_i = 1'b1;
            ddr_read_data_end_i   = (k == drain_beats - 1);
            ddr_read_data_i       = $urandom;
            tick();
            ddr_read_data_valid_i = 1'b0;
            ddr_read_data_end_i   = 1'b0;
            check_eq("drain_no_pulse", 64'({wb_valid_o, done_o}), 64'b00);
            check_eq("drain_ready", 64'(ready_o), 64'(k == drain_beats - 1));
            check_eq("drain_wb_hold", 64'(wb_data_o), 64'(last_wb));
        end
    endtask

    // Reset while a load waits for data; the later beat must be ignored
    task automatic reset_in_rdwait();
        check_eq("rst_test_ready", 64'(ready_o), 64'd1);
        valid_i          = 1'b1;
        op_i             = 3'd4;
        memory_address_i = 29'h10;
        destination_i    = 32'h0000_0077;
        tick();
        valid_i       = 1'b0;
        ddr_cmd_rdy_i = 1'b1;
        tick();
        ddr_cmd_rdy_i = 1'b0;
        check_eq("rst_test_in_rdwait", 64'({ddr_enable_o, ready_o}), 64'b00);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_mid_pulses", 64'({misalign_o, done_o, timeout_o, wb_valid_o, ddr_enable_o}), 64'd0);
        check_eq("rst_mid_ready", 64'(ready_o), 64'd1);
        check_eq("rst_mid_wbdata", 64'(wb_data_o), 64'd0);
        check_eq("rst_mid_ddr", 64'({ddr_cmd_o, ddr_addr_o, ddr_wr_mask_o}), 64'd0);
        last_wb = 32'd0;
        ddr_read_data_valid_i = 1'b1;
        ddr_read_data_end_i   = 1'b1;
        ddr_read_data_i       = 32'h1234_5678;
        tick();
        ddr_read_data_valid_i = 1'b0;
        ddr_read_data_end_i   = 1'b0;
        check_eq("rst_late_beat", 64'({wb_valid_o, done_o, ready_o}), 64'b001);
        check_eq("rst_late_wbdata", 64'(wb_data_o), 64'd0);
    endtask

    initial begin
        logic [2:0]        r_op;
        logic [ADDR_W-1:0] r_addr;
        int                sz;

        rst                   = 1'b1;
        valid_i               = 1'b0;
        op_i                  = 3'd0;
        memory_address_i      = '0;
        store_data_i          = 32'd0;
        destination_i         = '0;
        ddr_cmd_rdy_i         = 1'b0;
        ddr_read_data_i       = '0;
        ddr_read_data_valid_i = 1'b0;
        ddr_read_data_end_i   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_eq("reset_ready", 64'(ready_o), 64'd1);
        check_eq("reset_pulses", 64'({misalign_o, done_o, timeout_o, wb_valid_o, ddr_enable_o}), 64'd0);
        check_eq("reset_data", 64'({wb_data_o, destination_o}), 64'd0);
        check_eq("reset_ddr", 64'({ddr_cmd_o, ddr_addr_o, ddr_wr_data_o}), 64'd0);

        // signed byte load from the top lane
        run_txn(3'd0, 29'h003, 32'd0, 32'hA5A5_0001, 0, 0, 32'h8000_0000, 0, 1'b0);
        check_eq("ldb_const", 64'(wb_data_o), 64'hFFFF_FF80);
        // unsigned and signed halfword from the upper half
        run_txn(3'd3, 29'h002, 32'd0, 32'h0000_0002, 1, 2, 32'hBEEF_1234, 0, 1'b0);
        check_eq("ldhu_const", 64'(wb_data_o), 64'h0000_BEEF);
        run_txn(3'd2, 29'h002, 32'd0, 32'h0000_0003, 0, 1, 32'hBEEF_1234, 0, 1'b0);
        check_eq("ldh_const", 64'(wb_data_o), 64'hFFFF_BEEF);
        // halfword store held through three stalled cycles
        run_txn(3'd6, 29'h006, 32'h0000_ABCD, 32'h0000_0004, 3, 0, 32'd0, 0, 1'b0);
        // misaligned word load
        run_txn(3'd4, 29'h002, 32'd0, 32'h0000_0005, 0, 0, 32'd0, 0, 1'b0);
        // load never answered, then a stray beat
        run_txn(3'd4, 29'h040, 32'd0, 32'h0000_0006, 0, 99, 32'hDEAD_BEEF, 0, 1'b0);
        // command never accepted
        run_txn(3'd7, 29'h044, 32'h1122_3344, 32'h0000_0007, 99, 0, 32'd0, 0, 1'b0);
        // multi-beat burst drained after the first beat; last-chance acceptance
        run_txn(3'd1, 29'h001, 32'd0, 32'h0000_0008, TIMEOUT - 1, TIMEOUT - 1, 32'h0000_F100, 2, 1'b1);
        reset_in_rdwait();

        for (int n = 0; n < 80; n++) begin
            r_op   = 3'($urandom);
            r_addr = ADDR_W'($urandom);
            sz     = op_size(r_op);
            if ($urandom_range(0, 4) != 0) r_addr = r_addr - ADDR_W'(int'(r_addr[1:0]) % sz);
            run_txn(r_op, r_addr, $urandom, DST_W'($urandom),
                    $urandom_range(0, TIMEOUT + 1), $urandom_range(0, TIMEOUT + 1),
                    $urandom, $urandom_range(0, 2), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DDR_W, default 32, DDR data bus width; legal values 32 and 64.
REQ-002 Parameter ADDR_W, default 29, byte address width.
REQ-003 Parameter DST_W, default 32, destination tag width.
REQ-004 Parameter TIMEOUT, default 255, max wait cycles in CMD or RDWAIT; legal range 1..65535.
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 valid_i  in  1  request present; sampled only when ready_o=1.
REQ-008 ready_o  out  1  unit idle, request accepted this cycle if valid_i=1.
REQ-009 op_i  in  3  000 LD.B, 001 LD.BU, 010 LD.H, 011 LD.HU, 100 LD.W, 101 ST.B, 110 ST.H, 111 ST.W.
REQ-010 memory_address_i  in  ADDR_W  byte address.
REQ-011 store_data_i  in  32  store data, low bits significant for B/H.
REQ-012 destination_i  in  DST_W  writeback tag.
REQ-013 wb_valid_o  out  1  one-cycle pulse, load result valid.
REQ-014 wb_data_o  out  32  extended load result.
REQ-015 destination_o  out  DST_W  tag of completed request.
REQ-016 done_o  out  1  one-cycle pulse, any request retired (load, store, fault).
REQ-017 misalign_o  out  1  one-cycle pulse, misaligned request rejected.
REQ-018 timeout_o  out  1  one-cycle pulse, request abandoned on timeout.
REQ-019 ddr_cmd_rdy_i  in  1  DDR3 IP accepts command this cycle.
REQ-020 ddr_enable_o  out  1  command valid to DDR3 IP.
REQ-021 ddr_cmd_o  out  1  0 read, 1 write.
REQ-022 ddr_addr_o  out  ADDR_W  address with low log2(DDR_W/8) bits zeroed.
REQ-023 ddr_wr_data_o  out  DDR_W  write data; ddr_wr_mask_o  out  DDR_W/8  1 = byte not written.
REQ-024 ddr_read_data_i  in  DDR_W; ddr_read_data_valid_i  in  1; ddr_read_data_end_i  in  1  last beat.

Function
REQ-025 States IDLE, CMD, RDWAIT, DRAIN; ready_o=1 only in IDLE, combinational from state.
REQ-026 IDLE with valid_i=1 latches op, address, store data and tag; aligned request -> CMD next cycle.
REQ-027 Misaligned (H with addr[0]=1, W with addr[1:0]!=0) stays IDLE, no DDR command, pulses misalign_o and done_o next cycle.
REQ-028 CMD drives ddr_enable_o=1 with ddr_cmd_o/addr/wdata/mask registered and stable until a cycle with ddr_cmd_rdy_i=1.
REQ-029 Command accepted: store -> IDLE with done_o pulse next cycle; load -> RDWAIT.
REQ-030 ddr_enable_o SHALL be 0 in the cycle after acceptance and in all non-CMD states.
REQ-031 Store lanes: byte offset = addr[log2(DDR_W/8)-1:0]; B/H/W data replicated across the bus; mask 0 only on addressed 1/2/4 bytes.
REQ-032 RDWAIT: first beat with ddr_read_data_valid_i=1 is selected by byte offset, sign-extended (LD.B, LD.H) or zero-extended (LD.BU, LD.HU, LD.W).
REQ-033 Load result: wb_data_o, destination_o, wb_valid_o=1, done_o=1 registered one cycle after the valid beat; wb_data_o holds until next load.
REQ-034 Valid beat with ddr_read_data_end_i=1 -> IDLE; without -> DRAIN, discarding beats until one with end=1, then IDLE.
REQ-035 Load latency: accept at T, command at T+1 if rdy, data valid at T+k gives wb_valid_o at T+k+1.
REQ-036 16-bit wait counter cleared on entry to CMD and RDWAIT; at TIMEOUT cycles without progress -> IDLE, timeout_o and done_o pulse, no wb_valid_o.
REQ-037 Read beats arriving in IDLE or CMD are ignored.
REQ-038 Back-to-back: request accepted in the first IDLE cycle after retirement; no bubble beyond the state return.
REQ-039 All pulse outputs are 0 on every cycle they are not explicitly asserted.

Reset
REQ-040 rst=1 forces IDLE, counter 0; all outputs 0 except ready_o=1 on the following cycle.
REQ-041 Reset mid-operation abandons the request with no done_o; ddr_enable_o=0 after the reset edge; late read beats are ignored.

Verification
REQ-042 DDR_W=32, LD.B addr 0x003, beat 0x80000000 end=1 -> wb_data_o 0xFFFFFF80, tag echoed, wb_valid_o one cycle.
REQ-043 LD.HU addr 0x002, beat 0xBEEF1234 -> wb_data_o 0x0000BEEF; LD.H same -> 0xFFFFBEEF.
REQ-044 ST.H addr 0x006, data 0x0000ABCD, cmd_rdy low 3 cycles -> addr 0x004, wdata 0xABCDABCD, mask 4'b0011 held 4 cycles, done_o after rdy.
REQ-045 LD.W addr 0x002 -> misalign_o=1 one cycle, ddr_enable_o never high, ready_o stays 1.
REQ-046 LD with no read valid for TIMEOUT=4 -> timeout_o at 5th wait cycle, IDLE; stray beat afterwards -> no wb_valid_o.
REQ-047 rst asserted in RDWAIT, then beat arrives -> no wb_valid_o or done_o, outputs 0, ready_o=1.
